// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE/ACCESS/RESP sequencer serialising port 0 (core) and port 1 (loader).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              win_port;
  logic              lat_we;

  logic              any_req;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  // Port that received the most recent grant; reset value makes port 0 win the first tie.
  logic last_port;

  always_comb begin
    sel_port = 1'b0;
    if (req0 && req1) begin
      sel_port = ~last_port;
    end else begin
      sel_port = ~req0;
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is silent.
  always_comb begin
    sel_port = ~req0;
  end
`endif

  always_comb begin
    any_req   = req0 | req1;
    sel_we    = sel_port ? we1    : we0;
    sel_addr  = sel_port ? addr1  : addr0;
    sel_wdata = sel_port ? wdata1 : wdata0;
  end

  // Sequencer: all outputs are registered; pulses default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      win_port  <= 1'b0;
      lat_we    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_port <= 1'b1;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            win_port  <= sel_port;
            lat_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            wait_cnt  <= WAIT_INIT;
            gnt0      <= ~sel_port;
            gnt1      <= sel_port;
            // With no wait states the first ACCESS cycle is also the write cycle.
            mem_we    <= sel_we && (WAIT_INIT == 4'd0);
`ifdef DMEM_ARB_RR_EN
            last_port <= sel_port;
`endif
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state   <= RESP;
            rvalid0 <= ~win_port;
            rvalid1 <= win_port;
            if (!lat_we) begin
              if (win_port) begin
                rdata1 <= mem_rdata;
              end else begin
                rdata0 <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            mem_we   <= lat_we && (wait_cnt == 4'd1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_gnt:    assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
  a_one_rvalid: assert property (@(posedge clk) disable iff (reset) !(rvalid0 && rvalid1));
  a_we_access:  assert property (@(posedge clk) disable iff (reset) mem_we |-> (state == ACCESS));
`endif

endmodule
